// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT frame controller and its output monitor.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  localparam logic [31:0] PTS_MIN = 32'd8;
  localparam logic [31:0] PTS_MAX = 32'd512;

  // A frame length is usable only if it is a single power of two inside the core's range.
  function automatic logic pts_valid(input logic [31:0] pts);
    return (pts >= PTS_MIN) && (pts <= PTS_MAX) && ((pts & (pts - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fft_frame_mon.sv
// Watches the core's output stream: checks sop/eop placement and error codes,
// and counts completed output frames.
module fft_frame_mon
  import fft_ctrl_pkg::*;
#(
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  logic          ready,
  input  logic          sop,
  input  logic          eop,
  input  logic [1:0]    error,
  input  logic [PW-1:0] fftpts,
  output logic          frame_err,
  output logic [15:0]   frames_done
);

  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] pts_q, pts_d;
  logic          frame_err_q, frame_err_d;
  logic [15:0]   frames_done_q, frames_done_d;
  logic          fire;
  logic          beat_bad;
  logic [PW-1:0] cur_pts;

  assign fire    = valid & ready;
  assign cur_pts = sop ? fftpts : pts_q;

  // A beat is wrong if sop or eop is present where it must not be, or absent where it must be.
  assign beat_bad = (sop != (count_q == '0)) ||
                    (eop != (count_q == cur_pts - PW'(1))) ||
                    (error != 2'b00);

  always_comb begin
    count_d       = count_q;
    pts_d         = pts_q;
    frame_err_d   = frame_err_q;
    frames_done_d = frames_done_q;
    if (fire) begin
      if (sop) begin
        pts_d = fftpts;
      end
      if (eop) begin
        count_d       = '0;
        frames_done_d = frames_done_q + 16'd1;
      end else if (sop) begin
        count_d = PW'(1);
      end else begin
        count_d = count_q + PW'(1);
      end
      if (beat_bad) begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      pts_q         <= PW'(PTS_MIN);
      frame_err_q   <= 1'b0;
      frames_done_q <= 16'd0;
    end else begin
      count_q       <= count_d;
      pts_q         <= pts_d;
      frame_err_q   <= frame_err_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign frame_err   = frame_err_q;
  assign frames_done = frames_done_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames a real-valued sample stream into an FFT core and passes its output
// downstream; frame length and direction only change on frame boundaries.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [PW-1:0] cfg_pts,
  input  logic          cfg_inverse,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          fft_sink_valid,
  input  logic          fft_sink_ready,
  output logic          fft_sink_sop,
  output logic          fft_sink_eop,
  output logic [DW-1:0] fft_sink_real,
  output logic [DW-1:0] fft_sink_imag,
  output logic [1:0]    fft_sink_error,
  output logic [PW-1:0] fft_fftpts_in,
  output logic          fft_inverse,
  input  logic          fft_source_valid,
  output logic          fft_source_ready,
  input  logic          fft_source_sop,
  input  logic          fft_source_eop,
  input  logic [1:0]    fft_source_error,
  input  logic [DW-1:0] fft_source_real,
  input  logic [DW-1:0] fft_source_imag,
  input  logic [PW-1:0] fft_fftpts_out,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic          busy,
  output logic          cfg_err,
  output logic          frame_err,
  output logic [15:0]   frames_done
);

  state_t        state_q, state_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] shadow_pts_q, shadow_pts_d;
  logic          shadow_inv_q, shadow_inv_d;
  logic          cfg_err_q, cfg_err_d;
  logic          armed_q, armed_d;
  logic          active;
  logic          cfg_ok;
  logic          sink_fire;
  logic          sink_eop;

  assign active    = (state_q != IDLE);
  assign cfg_ok    = pts_valid(32'(cfg_pts));
  assign sink_fire = in_valid & fft_sink_ready & active;
  assign sink_eop  = (count_q == shadow_pts_q - PW'(1));

  assign fft_sink_valid = in_valid & active;
  assign in_ready       = fft_sink_ready & active;
  assign fft_sink_sop   = (count_q == '0);
  assign fft_sink_eop   = sink_eop;
  assign fft_sink_real  = in_data;
  assign fft_sink_imag  = '0;
  assign fft_sink_error = 2'b00;
  assign fft_fftpts_in  = shadow_pts_q;
  assign fft_inverse    = shadow_inv_q;
  assign busy           = active;
  assign cfg_err        = cfg_err_q;

  // armed_q lets a rejected config report only once until enable drops and rises again.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shadow_pts_d = shadow_pts_q;
    shadow_inv_d = shadow_inv_q;
    cfg_err_d    = 1'b0;
    armed_d      = enable ? armed_q : 1'b1;
    case (state_q)
      IDLE: begin
        if (enable) begin
          armed_d = 1'b0;
          if (cfg_ok) begin
            state_d      = RUN;
            count_d      = '0;
            shadow_pts_d = cfg_pts;
            shadow_inv_d = cfg_inverse;
          end else if (armed_q) begin
            cfg_err_d = 1'b1;
          end
        end
      end
      default: begin
        if (sink_fire) begin
          if (sink_eop) begin
            count_d = '0;
            if (cfg_ok) begin
              shadow_pts_d = cfg_pts;
              shadow_inv_d = cfg_inverse;
            end else begin
              cfg_err_d = 1'b1;
            end
          end else begin
            count_d = count_q + PW'(1);
          end
        end
        // Stopping waits for the running frame to close; a fresh boundary stops at once.
        if (enable) begin
          state_d = RUN;
        end else if (count_d != '0) begin
          state_d = STOP_PEND;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shadow_pts_q <= PW'(PTS_MIN);
      shadow_inv_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      armed_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shadow_pts_q <= shadow_pts_d;
      shadow_inv_q <= shadow_inv_d;
      cfg_err_q    <= cfg_err_d;
      armed_q      <= armed_d;
    end
  end

  assign out_valid        = fft_source_valid;
  assign out_sop          = fft_source_sop;
  assign out_eop          = fft_source_eop;
  assign out_real         = fft_source_real;
  assign out_imag         = fft_source_imag;
  assign fft_source_ready = out_ready;

  fft_frame_mon #(
    .PW(PW)
  ) u_mon (
    .clk        (clk),
    .reset      (reset),
    .valid      (fft_source_valid),
    .ready      (out_ready),
    .sop        (fft_source_sop),
    .eop        (fft_source_eop),
    .error      (fft_source_error),
    .fftpts     (fft_fftpts_out),
    .frame_err  (frame_err),
    .frames_done(frames_done)
  );

endmodule
